// File: rtl/quad_pkg.sv
// Shared definitions for the command arbiter and the command-config block:
// opcodes, the response-timeout code, the arbiter state encoding and timer widths.
package quad_pkg;

  localparam logic [7:0] OP_SET_PTCH  = 8'h02;
  localparam logic [7:0] OP_SET_ROLL  = 8'h03;
  localparam logic [7:0] OP_SET_YAW   = 8'h04;
  localparam logic [7:0] OP_SET_THRST = 8'h05;
  localparam logic [7:0] OP_CALIBRATE = 8'h06;
  localparam logic [7:0] OP_EMER_LAND = 8'h07;
  localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

  localparam logic [7:0] RESP_TMO = 8'hEE;

  localparam int RSP_TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_WAIT,
    ST_FS_LAND,
    ST_FS_LWAIT,
    ST_FS_HOLD,
    ST_FS_OFF,
    ST_FS_OWAIT
  } arb_state_t;

  // Link watchdog and failsafe hold share one width: short for simulation, ~1.3 s at 50 MHz otherwise.
  function automatic int link_tmr_w(input bit fast_sim);
    return fast_sim ? 9 : 26;
  endfunction

endpackage

// File: rtl/cmd_arb_if.sv
// Command/ack handshake between the arbiter (master) and the command-config block (slave).
interface cmd_arb_if;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;

  modport master (
    output cmd_rdy, cmd, data,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    input  cmd_rdy, cmd, data,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/sat_tmr.sv
// Up-counter that clears on clr, otherwise counts once per cycle and sticks at all-ones.
module sat_tmr #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic full
);

  logic [WIDTH-1:0] cnt;

  assign full = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (!full)
      cnt <= cnt + WIDTH'(1);
  end

endmodule

// File: rtl/cmd_arb.sv
// Arbitrates between remote commands and the internal link-loss failsafe sequence
// (emergency land, hold, motors off) towards the command-config block.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// IDLE      | nothing in flight; failsafe entry or remote capture decided here
// FWD       | remote command presented, waiting for consume
// WAIT      | remote command consumed, waiting for ack or response timeout
// FS_LAND   | emergency-land command presented
// FS_LWAIT  | waiting for land ack or timeout (ack swallowed)
// FS_HOLD   | holding for the hold timer before cutting motors
// FS_OFF    | motors-off command presented
// FS_OWAIT  | waiting for motors-off ack or timeout (ack swallowed)
module cmd_arb
  import quad_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rmt_rdy,
  input  logic [7:0]       rmt_cmd,
  input  logic [15:0]      rmt_data,
  output logic             clr_rmt_rdy,
  output logic [7:0]       rmt_resp,
  output logic             rmt_send_resp,
  cmd_arb_if.master        cfg,
  output logic             link_lost,
  output logic             failsafe
);

  localparam int LINK_W = link_tmr_w(FAST_SIM != 0);

  arb_state_t state, state_nx;

  logic cap_rmt, ld_land, ld_off;
  logic clr_rsp, clr_hold;
  logic fs_set, fs_clr;
  logic ack_resp, ack_tmo;
  logic rsp_tmo, hold_done;

  sat_tmr #(.WIDTH(LINK_W)) u_wdog (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cap_rmt),
    .full (link_lost)
  );

  sat_tmr #(.WIDTH(LINK_W)) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_hold),
    .full (hold_done)
  );

  sat_tmr #(.WIDTH(RSP_TMR_W)) u_rsp (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_rsp),
    .full (rsp_tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    clr_rmt_rdy = 1'b0;
    cap_rmt     = 1'b0;
    ld_land     = 1'b0;
    ld_off      = 1'b0;
    clr_rsp     = 1'b0;
    clr_hold    = 1'b0;
    fs_set      = 1'b0;
    fs_clr      = 1'b0;
    ack_resp    = 1'b0;
    ack_tmo     = 1'b0;
    cfg.cmd_rdy = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // Failsafe entry wins; a simultaneous remote command stays pending.
        if (link_lost && !failsafe) begin
          state_nx = ST_FS_LAND;
          fs_set   = 1'b1;
          ld_land  = 1'b1;
        end else if (rmt_rdy) begin
          state_nx    = ST_FWD;
          cap_rmt     = 1'b1;
          clr_rmt_rdy = 1'b1;
        end
      end
      ST_FWD: begin
        cfg.cmd_rdy = 1'b1;
        if (cfg.clr_cmd_rdy) begin
          state_nx = ST_WAIT;
          clr_rsp  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cfg.send_resp) begin
          state_nx = ST_IDLE;
          ack_resp = 1'b1;
          fs_clr   = 1'b1;
        end else if (rsp_tmo) begin
          state_nx = ST_IDLE;
          ack_tmo  = 1'b1;
        end
      end
      ST_FS_LAND: begin
        cfg.cmd_rdy = 1'b1;
        if (cfg.clr_cmd_rdy) begin
          state_nx = ST_FS_LWAIT;
          clr_rsp  = 1'b1;
        end
      end
      ST_FS_LWAIT: begin
        if (cfg.send_resp || rsp_tmo) begin
          state_nx = ST_FS_HOLD;
          clr_hold = 1'b1;
        end
      end
      ST_FS_HOLD: begin
        if (hold_done) begin
          state_nx = ST_FS_OFF;
          ld_off   = 1'b1;
        end
      end
      ST_FS_OFF: begin
        cfg.cmd_rdy = 1'b1;
        if (cfg.clr_cmd_rdy) begin
          state_nx = ST_FS_OWAIT;
          clr_rsp  = 1'b1;
        end
      end
      ST_FS_OWAIT: begin
        if (cfg.send_resp || rsp_tmo)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cmd       <= 8'h00;
      cfg.data      <= 16'h0000;
      rmt_resp      <= 8'h00;
      rmt_send_resp <= 1'b0;
      failsafe      <= 1'b0;
    end else begin
      rmt_send_resp <= ack_resp | ack_tmo;

      if (cap_rmt) begin
        cfg.cmd  <= rmt_cmd;
        cfg.data <= rmt_data;
      end else if (ld_land) begin
        cfg.cmd  <= OP_EMER_LAND;
        cfg.data <= 16'h0000;
      end else if (ld_off) begin
        cfg.cmd  <= OP_MTRS_OFF;
        cfg.data <= 16'h0000;
      end

      if (ack_resp)
        rmt_resp <= cfg.resp;
      else if (ack_tmo)
        rmt_resp <= RESP_TMO;

      if (fs_set)
        failsafe <= 1'b1;
      else if (fs_clr)
        failsafe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmd_arb.sv
// Directed plus randomized bench for cmd_arb: expected values come from the
// arbitration rules (constants and timer lengths as powers of two), not from the DUT.
module tb_cmd_arb;
  import quad_pkg::*;

  localparam int LINK_W = 9;
  localparam int RSP_LAT = 2 ** RSP_TMR_W;
  localparam int HOLD_LAT = 2 ** LINK_W;
  localparam int WDOG_LAT = 2 ** LINK_W - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rmt_rdy = 1'b0;
  logic [7:0]  rmt_cmd = 8'h00;
  logic [15:0] rmt_data = 16'h0000;
  logic        clr_rmt_rdy;
  logic [7:0]  rmt_resp;
  logic        rmt_send_resp;
  logic        link_lost;
  logic        failsafe;

  cmd_arb_if bus ();

  cmd_arb #(.FAST_SIM(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rmt_rdy      (rmt_rdy),
    .rmt_cmd      (rmt_cmd),
    .rmt_data     (rmt_data),
    .clr_rmt_rdy  (clr_rmt_rdy),
    .rmt_resp     (rmt_resp),
    .rmt_send_resp(rmt_send_resp),
    .cfg          (bus.master),
    .link_lost    (link_lost),
    .failsafe     (failsafe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;

  always @(negedge clk) if (rst_n && rmt_send_resp) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return rmt_send_resp;
      1:       return bus.cmd_rdy;
      2:       return clr_rmt_rdy;
      default: return link_lost;
    endcase
  endfunction

  // Advance negedge by negedge until the selected output is high; n = edges waited.
  task automatic wait_for(input int sel, input int max, input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pick(sel) && n < max);
    check({tag, "_seen"}, 32'(pick(sel)), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_rdy"}, 32'(bus.cmd_rdy), 0);
    check({tag, "_clr_rmt_rdy"}, 32'(clr_rmt_rdy), 0);
    check({tag, "_rmt_send_resp"}, 32'(rmt_send_resp), 0);
    check({tag, "_cmd"}, 32'(bus.cmd), 0);
    check({tag, "_data"}, 32'(bus.data), 0);
    check({tag, "_rmt_resp"}, 32'(rmt_resp), 0);
    check({tag, "_failsafe"}, 32'(failsafe), 0);
    check({tag, "_link_lost"}, 32'(link_lost), 0);
  endtask

  // One remote command end to end; answer=0 lets the response timer expire.
  task automatic fwd_cmd(input logic [7:0] c, input logic [15:0] d, input int hold,
                         input bit answer, input int dly, input logic [7:0] r,
                         input bit fs_after);
    int n;
    @(negedge clk);
    rmt_cmd  = c;
    rmt_data = d;
    rmt_rdy  = 1'b1;
    #1;
    check("clr_rmt_rdy_pulse", 32'(clr_rmt_rdy), 1);
    @(negedge clk);
    rmt_rdy  = 1'b0;
    rmt_cmd  = 8'($urandom);
    rmt_data = 16'($urandom);
    #1;
    check("clr_rmt_rdy_drop", 32'(clr_rmt_rdy), 0);
    check("fwd_cmd_rdy", 32'(bus.cmd_rdy), 1);
    check("fwd_cmd", 32'(bus.cmd), 32'(c));
    check("fwd_data", 32'(bus.data), 32'(d));
    repeat (hold) @(negedge clk);
    check("fwd_hold_cmd_rdy", 32'(bus.cmd_rdy), 1);
    check("fwd_hold_cmd", 32'(bus.cmd), 32'(c));
    check("fwd_hold_data", 32'(bus.data), 32'(d));
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check("wait_cmd_rdy_low", 32'(bus.cmd_rdy), 0);
    if (answer) begin
      repeat (dly) @(negedge clk);
      check("wait_no_early_ack", 32'(rmt_send_resp), 0);
      bus.resp      = r;
      bus.send_resp = 1'b1;
      @(negedge clk);
      bus.send_resp = 1'b0;
      bus.resp      = 8'($urandom);
      check("ack_pulse", 32'(rmt_send_resp), 1);
      check("ack_resp", 32'(rmt_resp), 32'(r));
    end else begin
      wait_for(0, RSP_LAT + 20, "tmo_ack", n);
      check("tmo_latency", 32'(n), 32'(RSP_LAT));
      check("tmo_resp", 32'(rmt_resp), 32'(RESP_TMO));
    end
    check("ack_failsafe", 32'(failsafe), 32'(fs_after));
    @(negedge clk);
    check("ack_one_cycle", 32'(rmt_send_resp), 0);
  endtask

  initial begin
    int n;
    int acks0;
    logic [7:0] ops [4];
    ops[0] = OP_SET_THRST;
    ops[1] = OP_CALIBRATE;
    ops[2] = OP_SET_PTCH;
    ops[3] = OP_SET_YAW;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.resp        = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;

    // Basic forward and ack
    fwd_cmd(OP_SET_PTCH, 16'h1234, 2, 1'b1, 5, 8'hA5, 1'b0);

    // Response timeout
    fwd_cmd(OP_SET_ROLL, 16'h00C3, 0, 1'b0, 0, 8'h00, 1'b0);

    // Stray consume/ack while idle are ignored
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    bus.send_resp   = 1'b1;
    bus.resp        = 8'h3C;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    check("stray_cmd_rdy", 32'(bus.cmd_rdy), 0);
    check("stray_ack", 32'(rmt_send_resp), 0);
    @(negedge clk);
    check("stray_ack2", 32'(rmt_send_resp), 0);
    check("stray_resp_kept", 32'(rmt_resp), 32'(RESP_TMO));

    // Randomized traffic
    for (int i = 0; i < 16; i++) begin
      logic [7:0]  c;
      logic [15:0] d;
      bit          ans;
      c   = ops[$urandom_range(3, 0)];
      d   = 16'($urandom);
      ans = ($urandom_range(3, 0) != 0);
      fwd_cmd(c, d, $urandom_range(4, 0), ans, $urandom_range(200, 0), 8'($urandom), 1'b0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    // Link loss with a remote command arriving in the same cycle
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst2");
    rst_n = 1'b1;
    acks0 = ack_cnt;
    wait_for(3, WDOG_LAT + 20, "link_lost", n);
    check("wdog_latency", 32'(n), 32'(WDOG_LAT));
    rmt_cmd  = OP_SET_ROLL;
    rmt_data = 16'hBEEF;
    rmt_rdy  = 1'b1;
    #1;
    check("fs_priority_no_clr", 32'(clr_rmt_rdy), 0);
    @(negedge clk);
    check("land_cmd_rdy", 32'(bus.cmd_rdy), 1);
    check("land_cmd", 32'(bus.cmd), 32'(OP_EMER_LAND));
    check("land_data", 32'(bus.data), 0);
    check("land_failsafe", 32'(failsafe), 1);
    check("land_no_clr", 32'(clr_rmt_rdy), 0);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check("lwait_cmd_rdy_low", 32'(bus.cmd_rdy), 0);
    repeat (3) @(negedge clk);
    bus.resp      = 8'h11;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    check("land_ack_swallowed", 32'(rmt_send_resp), 0);
    wait_for(1, HOLD_LAT + 20, "off_cmd_rdy", n);
    check("hold_latency", 32'(n), 32'(HOLD_LAT));
    check("off_cmd", 32'(bus.cmd), 32'(OP_MTRS_OFF));
    check("off_data", 32'(bus.data), 0);
    check("off_failsafe", 32'(failsafe), 1);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    wait_for(2, RSP_LAT + 20, "pending_capture", n);
    check("owait_tmo_latency", 32'(n), 32'(RSP_LAT));
    check("capture_failsafe_still", 32'(failsafe), 1);
    check("fs_no_acks", 32'(ack_cnt - acks0), 0);
    @(negedge clk);
    rmt_rdy = 1'b0;
    check("pend_cmd_rdy", 32'(bus.cmd_rdy), 1);
    check("pend_cmd", 32'(bus.cmd), 32'(OP_SET_ROLL));
    check("pend_data", 32'(bus.data), 32'h0000BEEF);
    check("pend_link_ok", 32'(link_lost), 0);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    repeat (4) @(negedge clk);
    bus.resp      = 8'h5A;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    check("pend_ack", 32'(rmt_send_resp), 1);
    check("pend_resp", 32'(rmt_resp), 32'h5A);
    check("pend_failsafe_clear", 32'(failsafe), 0);

    // Reset during the failsafe hold
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_for(3, WDOG_LAT + 20, "link_lost2", n);
    @(negedge clk);
    check("land2_cmd", 32'(bus.cmd), 32'(OP_EMER_LAND));
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    repeat (100) @(negedge clk);
    acks0 = ack_cnt;
    rst_n = 1'b0;
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_idle", 32'(bus.cmd_rdy), 0);
    check("post_rst_no_ack", 32'(ack_cnt - acks0), 0);
    fwd_cmd(OP_SET_YAW, 16'h0042, 1, 1'b1, 7, 8'h77, 1'b0);
    check("post_rst_one_ack", 32'(ack_cnt - acks0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_arb.md
CMD_ARB -- requirements
Module: cmd_arb

Interface
REQ-001 Parameter FAST_SIM, default 1: 1 selects short timers for simulation, 0 selects real-time timers.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rmt_rdy  input  1  remote command valid, from the UART wrapper.
REQ-005 rmt_cmd  input  8  remote opcode.
REQ-006 rmt_data  input  16  remote operand.
REQ-007 clr_rmt_rdy  output  1  one-cycle pulse when a remote command is captured.
REQ-008 rmt_resp  output  8  response byte to the remote.
REQ-009 rmt_send_resp  output  1  one-cycle pulse that sends rmt_resp.
REQ-010 cmd_rdy  output  1  command valid to the command-config block.
REQ-011 cmd  output  8  opcode to the command-config block.
REQ-012 data  output  16  operand to the command-config block.
REQ-013 clr_cmd_rdy  input  1  consume pulse from the command-config block.
REQ-014 resp  input  8  ack byte from the command-config block.
REQ-015 send_resp  input  1  ack-valid pulse from the command-config block.
REQ-016 link_lost  output  1  high while the link watchdog is saturated.
REQ-017 failsafe  output  1  high from failsafe entry until the first remote command completes.

Function
REQ-018 Watchdog: unsigned counter, 9 bits if FAST_SIM else 26 bits; cleared when a remote command is captured; otherwise +1 per cycle; saturates at all-ones; link_lost = saturated.
REQ-019 Hold timer: same width as the watchdog; cleared on entry to FS_HOLD; done when all-ones.
REQ-020 Response timer: 8 bits; cleared on entry to a WAIT state; timeout when it reaches 8'hFF.
REQ-021 States: IDLE, FWD, WAIT, FS_LAND, FS_LWAIT, FS_HOLD, FS_OFF, FS_OWAIT.
REQ-022 IDLE, link_lost=1 and failsafe=0: go to FS_LAND and set failsafe. This takes priority over a simultaneous rmt_rdy, which is left pending (no clr_rmt_rdy).
REQ-023 IDLE, rmt_rdy=1, failsafe path not taken: capture rmt_cmd/rmt_data into the cmd/data registers, pulse clr_rmt_rdy in the same cycle, clear the watchdog, go to FWD.
REQ-024 FWD: cmd_rdy=1 (first asserted the cycle after capture) and held until clr_cmd_rdy=1, then go to WAIT; cmd and data stay stable while cmd_rdy=1.
REQ-025 WAIT on send_resp: latch resp into rmt_resp, pulse rmt_send_resp the next cycle, clear failsafe, go to IDLE.
REQ-026 WAIT on timeout: rmt_resp=8'hEE, pulse rmt_send_resp, go to IDLE.
REQ-027 FS_LAND: cmd=8'h07, data=0, cmd_rdy=1 until clr_cmd_rdy, then go to FS_LWAIT.
REQ-028 FS_LWAIT: on send_resp or timeout go to FS_HOLD; the ack is swallowed (no rmt_send_resp).
REQ-029 FS_HOLD: on hold done go to FS_OFF.
REQ-030 FS_OFF: cmd=8'h08, data=0, cmd_rdy=1 until clr_cmd_rdy, then go to FS_OWAIT.
REQ-031 FS_OWAIT: on send_resp or timeout go to IDLE with failsafe still 1; the ack is swallowed.
REQ-032 No re-entry to failsafe while failsafe=1; a remote command pending in any FS_* state is captured on the next IDLE.
REQ-033 rmt_send_resp is never asserted for an internally sourced command.
REQ-034 clr_cmd_rdy or send_resp arriving in a state that does not expect it is ignored.

Reset
REQ-035 On rst_n low: state=IDLE; cmd_rdy=0, clr_rmt_rdy=0, rmt_send_resp=0, cmd=0, data=0, rmt_resp=0, failsafe=0; all timers=0.
REQ-036 Reset mid-operation aborts any sequence with no ack emitted; the watchdog restarts from 0.

Structure
REQ-037 Opcode constants (8'h02 to 8'h08), the timeout code 8'hEE and the state enum shall live in shared package quad_pkg, which the command-config block also imports.
REQ-038 One sub-module, sat_tmr (parameterized width, clr, full), shall implement the watchdog, hold and response timers.

Verification
REQ-039 rmt_rdy with cmd=02, data=16'h1234 -> clr_rmt_rdy pulse; cmd_rdy next cycle with cmd=02, data=1234; after send_resp with resp=A5 -> rmt_send_resp pulse next cycle, rmt_resp=A5.
REQ-040 FAST_SIM=1, no remote traffic for 511 cycles -> link_lost=1; cmd=07 issued, hold of 511 cycles, then cmd=08; no rmt_send_resp at any point.
REQ-041 rmt_rdy asserted in the same cycle link_lost rises -> failsafe sequence runs first; the remote command is forwarded after FS_OWAIT, and failsafe clears on its ack.
REQ-042 Forwarded command with no send_resp -> after 255 cycles rmt_send_resp pulses with rmt_resp=EE and the block returns to IDLE.
REQ-043 rst_n pulsed low during FS_HOLD -> all outputs at reset values, no ack emitted; a new remote command is then forwarded normally.
